// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD unit.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRIP,
    REDUCE,
    FIXUP,
    DONE
  } gcd_state_e;

  // Width of the optional accept-to-DONE cycle counter (worst case 2*XLEN+3).
  function automatic int unsigned cyc_width(input int unsigned xlen);
    return $clog2(2 * xlen + 4);
  endfunction

endpackage

// File: rtl/gcd_reduce_step.sv
// One combinational REDUCE iteration of Stein's algorithm.
module gcd_reduce_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] a_nxt_o,
  output logic [XLEN-1:0] b_nxt_o,
  output logic            equal_o
);

  logic [XLEN-1:0] a_minus_b;
  logic [XLEN-1:0] b_minus_a;

  assign a_minus_b = a_i - b_i;
  assign b_minus_a = b_i - a_i;

  // Equality only terminates once both operands are odd.
  assign equal_o = a_i[0] && b_i[0] && (a_i == b_i);

  always_comb begin
    a_nxt_o = a_i;
    b_nxt_o = b_i;
    if (!a_i[0]) begin
      a_nxt_o = a_i >> 1;
    end else if (!b_i[0]) begin
      b_nxt_o = b_i >> 1;
    end else if (a_i > b_i) begin
      a_nxt_o = a_minus_b >> 1;
    end else if (b_i > a_i) begin
      b_nxt_o = b_minus_a >> 1;
    end
  end

endmodule

// File: rtl/gcd_binary.sv
// Streaming binary (Stein) GCD with valid/ready on both sides.
// Optional GCD_BINARY_CYCLES_EN adds cycles_o, the accept-to-DONE cycle count.
module gcd_binary
  import gcd_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned KW   = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] gcd_o
`ifdef GCD_BINARY_CYCLES_EN
  ,
  output logic [cyc_width(XLEN)-1:0] cycles_o
`endif
);

  gcd_state_e      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0] a_nxt, b_nxt;
  logic            equal;

  gcd_reduce_step #(
    .XLEN(XLEN)
  ) u_reduce_step (
    .a_i    (a_q),
    .b_i    (b_q),
    .a_nxt_o(a_nxt),
    .b_nxt_o(b_nxt),
    .equal_o(equal)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          a_d = a_i;
          b_d = b_i;
          k_d = '0;
          if (a_i == '0 || b_i == '0) begin
            res_d   = a_i | b_i;
            state_d = DONE;
          end else begin
            state_d = STRIP;
          end
        end
      end
      STRIP: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (equal) begin
          state_d = FIXUP;
        end else begin
          a_d = a_nxt;
          b_d = b_nxt;
        end
      end
      FIXUP: begin
        res_d   = a_q << k_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign gcd_o       = res_q;

`ifdef GCD_BINARY_CYCLES_EN
  localparam int unsigned CW = cyc_width(XLEN);

  logic [CW-1:0] cyc_q, cyc_d;

  // Accept edge counts as cycle 1; every busy-state edge up to DONE entry adds one.
  always_comb begin
    cyc_d = cyc_q;
    unique case (state_q)
      IDLE:                 if (in_valid_i && in_ready_q) cyc_d = CW'(1);
      STRIP, REDUCE, FIXUP: cyc_d = cyc_q + CW'(1);
      default:              cyc_d = cyc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_binary.sv
// Scoreboard bench for gcd_binary: directed corner cases plus random operands.
module tb_gcd_binary;
  import gcd_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MAXLAT = 2 * XLEN + 3;

  logic            clk;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] gcd_out;
`ifdef GCD_BINARY_CYCLES_EN
  logic [cyc_width(XLEN)-1:0] cycles;
`endif

  gcd_binary #(
    .XLEN(XLEN)
  ) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a_in),
    .b_i        (b_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .gcd_o      (gcd_out)
`ifdef GCD_BINARY_CYCLES_EN
    ,
    .cycles_o   (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  function automatic logic [XLEN-1:0] ref_gcd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected none", gcd_out);
      end else begin
        check("result", gcd_out, exp_q.pop_front());
      end
    end
  end

  // Drive operands at posedge+1 and hold until accepted; returns just after the accept edge.
  task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int n;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    n = 0;
    while (!in_ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 400) begin
        check("accept_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(ref_gcd(a, b));
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from accept until out_valid; also reports whether in_ready stayed low.
  task automatic wait_valid(output int n, output bit busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!out_valid) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        check("valid_timeout", 1, 0);
        return;
      end
    end
    if (in_ready) busy_ok = 1'b0;
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drained", exp_q.size(), 0);
  endtask

  int lat;
  bit busy_ok;
  int strips;
  logic [XLEN-1:0] ra, rb, g;

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gcd", gcd_out, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_held", in_ready, 0);
    resetn = 1'b1;

    // (34, 289): latency bound and in_ready low until handshake.
    send(34, 289);
    wait_valid(lat, busy_ok);
    check("lat_34_289", lat <= MAXLAT, 1);
    check("busy_34_289", busy_ok, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_in_ready", in_ready, 0);
    pop_out();
    check("valid_drop", out_valid, 0);
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    // (48, 180): two common factors of two.
    send(48, 180);
    strips = 0;
    for (int i = 0; i < 200 && dut.state_q != REDUCE; i++) begin
      if (dut.state_q == STRIP && !dut.a_q[0] && !dut.b_q[0]) strips++;
      @(posedge clk);
      #1;
    end
    check("strip_shifts", strips, 2);
    check("k_value", dut.k_q, 2);
    wait_valid(lat, busy_ok);
    pop_out();

    // Zero operands finish one cycle after accept.
    send(0, 12);
    check("zero_lat_0_12", out_valid, 1);
    pop_out();
    send(0, 0);
    check("zero_lat_0_0", out_valid, 1);
    pop_out();

    send('1, '1);
    wait_valid(lat, busy_ok);
    pop_out();
    send(32'h8000_0000, 32'h4000_0000);
    wait_valid(lat, busy_ok);
    check("lat_pow2", lat <= MAXLAT, 1);
    pop_out();

    // Backpressure: result must stay put while the consumer stalls.
    send(1701, 199);
    wait_valid(lat, busy_ok);
    g = gcd_out;
    begin
      bit stable_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || gcd_out !== g) stable_ok = 1'b0;
      end
      check("bp_stable", stable_ok, 1);
    end
    check("bp_value", gcd_out, 1);
    pop_out();
    send(21, 14);
    wait_valid(lat, busy_ok);
    pop_out();

    // Random operands with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom() >> $urandom_range(0, 31);
      rb = $urandom() >> $urandom_range(0, 31);
      g  = XLEN'($urandom_range(0, 6));
      ra = ra << g;
      rb = rb << g;
      if (i % 10 == 0) ra = '0;
      send(ra, rb);
    end
    drain();
    out_ready = 1'b0;

    // Asynchronous reset in REDUCE clears outputs without a clock edge.
    send(1701, 199);
    for (int i = 0; i < 200 && dut.state_q != REDUCE; i++) begin
      @(posedge clk);
      #1;
    end
    check("in_reduce", dut.state_q, REDUCE);
    #2;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    check("arst_state", dut.state_q, IDLE);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_gcd", gcd_out, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    send(9, 6);
    wait_valid(lat, busy_ok);
    pop_out();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
